// File: rtl/axi_tb_pkg.sv
// Shared types and constants for the AXI read-burst generator: FSM states,
// AXI encodings, LFSR seeds/taps and the LFSR step function.
package axi_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR2_SEED = 16'h1D2C;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS  = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/axi_ostd_fifo.sv
// Tracking FIFO for outstanding read bursts; DEPTH must be a power of two so
// the pointers wrap naturally.
module axi_ostd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/axi_mst_rd_gen.sv
// AXI read-master traffic generator: issues LFSR-shaped INCR bursts, tracks them
// in order and counts response errors. Define MST_RREADY_RAND_EN for random RREADY.
module axi_mst_rd_gen #(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_ID_W        = 4,
  parameter int AXI_DATA_W      = 32,
  parameter int MST_OSTDREQ_NUM = 4
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  in_start,
  input  logic [7:0]            in_txn_num,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [7:0]            out_err_cnt,
  output logic                  out_arvalid,
  input  logic                  in_arready,
  output logic [AXI_ADDR_W-1:0] out_araddr,
  output logic [3:0]            out_arlen,
  output logic [2:0]            out_arsize,
  output logic [1:0]            out_arburst,
  output logic [AXI_ID_W-1:0]   out_arid,
  input  logic                  in_rvalid,
  output logic                  out_rready,
  input  logic [AXI_ID_W-1:0]   in_rid,
  input  logic [1:0]            in_rresp,
  input  logic [AXI_DATA_W-1:0] in_rdata,
  input  logic                  in_rlast
);

  import axi_tb_pkg::*;

  localparam int FIFO_W = AXI_ID_W + 4;

  state_e              state_q, state_d;
  logic [7:0]          txn_num_q;
  logic [7:0]          issued_q;
  logic [7:0]          err_cnt_q;
  logic [15:0]         lfsr_q;
  logic [4:0]          beat_q;
  logic                fifo_full, fifo_empty;
  logic [FIFO_W-1:0]   head;
  logic [AXI_ID_W-1:0] head_id;
  logic [3:0]          head_len;
  logic                start_ok, ar_hs, r_hs, r_err, fifo_pop;
  logic                unused_ok;

  assign start_ok = in_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign ar_hs    = out_arvalid && in_arready;
  assign r_hs     = in_rvalid && out_rready;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (srst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: all outputs of this block get a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    out_busy    = 1'b0;
    out_done    = 1'b0;
    out_arvalid = 1'b0;
    case (state_q)
      ST_IDLE: if (in_start) state_d = ST_ISSUE;
      ST_ISSUE: begin
        out_busy    = 1'b1;
        out_arvalid = (issued_q < txn_num_q) && !fifo_full;
        if (issued_q == txn_num_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_busy = 1'b1;
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_done = 1'b1;
        if (in_start) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload is a pure function of registers that only move on a handshake, so it holds under backpressure.
  assign out_araddr  = AXI_ADDR_W'(issued_q) << 6;
  assign out_arlen   = lfsr_q[3:0];
  assign out_arid    = lfsr_q[AXI_ID_W+3:4];
  assign out_arsize  = 3'($clog2(AXI_DATA_W/8));
  assign out_arburst = AXI_BURST_INCR;
  assign out_err_cnt = err_cnt_q;

  assign head_id  = head[FIFO_W-1:4];
  assign head_len = head[3:0];

  // One error per offending beat regardless of how many checks it trips.
  assign r_err = fifo_empty
              || (in_rid != head_id)
              || (in_rresp != AXI_RESP_OKAY)
              || ( in_rlast && (beat_q != {1'b0, head_len}))
              || (!in_rlast && (beat_q == {1'b0, head_len}));

  assign fifo_pop = r_hs && in_rlast && !fifo_empty;

  always_ff @(posedge aclk) begin
    if (srst) begin
      txn_num_q <= '0;
      issued_q  <= '0;
      err_cnt_q <= '0;
      lfsr_q    <= LFSR_SEED;
      beat_q    <= '0;
    end else begin
      if (start_ok) begin
        txn_num_q <= in_txn_num;
        issued_q  <= '0;
      end else if (ar_hs) begin
        issued_q <= issued_q + 8'd1;
      end
      if (ar_hs) lfsr_q <= lfsr_next(lfsr_q);
      if (r_hs)  beat_q <= in_rlast ? 5'd0 : beat_q + 5'd1;
      if (start_ok)
        err_cnt_q <= '0;
      else if (r_hs && r_err && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  axi_ostd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (MST_OSTDREQ_NUM)
  ) u_fifo (
    .aclk  (aclk),
    .srst  (srst),
    .push  (ar_hs),
    .din   ({out_arid, out_arlen}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MST_RREADY_RAND_EN
  logic [15:0] lfsr2_q;

  always_ff @(posedge aclk) begin
    if (srst) lfsr2_q <= LFSR2_SEED;
    else      lfsr2_q <= lfsr_next(lfsr2_q);
  end

  assign out_rready = out_busy && lfsr2_q[0];
`else
  assign out_rready = out_busy;
`endif

  // Read data is intentionally not inspected.
  assign unused_ok = ^in_rdata;

endmodule

// File: doc/axi_mst_rd_gen.md
AXI_MST_RD_GEN -- requirements
Module: axi_mst_rd_gen

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32: AR address width.
REQ-002 SHALL have parameter AXI_ID_W, default 4: ARID/RID width.
REQ-003 SHALL have parameter AXI_DATA_W, default 32: RDATA width.
REQ-004 SHALL have parameter MST_OSTDREQ_NUM, default 4 (power of 2, ≥2): outstanding read bursts.
REQ-005 SHALL have port aclk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port srst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_start  input  1  start pulse, sampled in IDLE/DONE only.
REQ-008 SHALL have port in_txn_num  input  8  bursts to issue, latched on start.
REQ-009 SHALL have port out_busy  output  1  high in ISSUE or DRAIN.
REQ-010 SHALL have port out_done  output  1  high in DONE.
REQ-011 SHALL have port out_err_cnt  output  8  saturating response-error count.
REQ-012 SHALL have port out_arvalid  output  1  AR valid.
REQ-013 SHALL have port in_arready  input  1  AR ready.
REQ-014 SHALL have port out_araddr  output  AXI_ADDR_W  AR address.
REQ-015 SHALL have port out_arlen  output  4  burst length minus one.
REQ-016 SHALL have port out_arsize  output  3  fixed $clog2(AXI_DATA_W/8).
REQ-017 SHALL have port out_arburst  output  2  fixed 2'b01 (INCR).
REQ-018 SHALL have port out_arid  output  AXI_ID_W  AR ID.
REQ-019 SHALL have ports in_rvalid input 1, out_rready output 1, in_rid input AXI_ID_W, in_rresp input 2, in_rdata input AXI_DATA_W, in_rlast input 1: R channel.

Function
REQ-020 SHALL implement FSM IDLE->ISSUE on in_start; ISSUE->DRAIN when issued count == latched txn_num; DRAIN->DONE when tracking FIFO empty; DONE->ISSUE on in_start; in_start ignored in ISSUE/DRAIN.
REQ-021 SHALL, on start, clear issued count and out_err_cnt; txn_num==0 gives ISSUE->DRAIN->DONE in 2 cycles, no AR issued.
REQ-022 SHALL assert out_arvalid in ISSUE when issued < txn_num and FIFO not full; AR payload held stable while out_arvalid && !in_arready.
REQ-023 SHALL derive payload from 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1): arlen = lfsr[3:0], arid = lfsr[AXI_ID_W+3:4]; araddr = issued count << 6, zero-extended; LFSR advances only on AR handshake.
REQ-024 SHALL push {arid, arlen} into tracking FIFO (depth MST_OSTDREQ_NUM) on AR handshake; pop on R handshake with in_rlast; simultaneous push+pop keeps occupancy; pointers wrap modulo depth.
REQ-025 SHALL count R beats per burst (5-bit counter), cleared on last-beat handshake.
REQ-026 SHALL increment out_err_cnt by one per R handshake if any: in_rid != head id; in_rresp != 2'b00; in_rlast asserted with beat != head len; in_rlast low with beat == head len; FIFO empty (no pop then); saturate at 255.
REQ-027 SHALL pop the head on an early or missing-rlast error only when in_rlast is seen; in-order responses only, interleaving is an error.
REQ-028 SHALL ignore in_rdata contents (no data check).

Reset
REQ-029 SHALL on srst set FSM IDLE, FIFO empty, counters 0, LFSR to seed, out_arvalid 0, out_rready 0, out_busy 0, out_done 0, out_err_cnt 0.
REQ-030 SHALL let srst mid-burst abandon all outstanding state; next cycle is IDLE.

Configuration
REQ-031 SHALL, with MST_RREADY_RAND_EN defined, drive out_rready from a second LFSR bit (lfsr2[0], separate 16-bit LFSR seed 16'h1D2C advancing every cycle) while busy.
REQ-032 SHALL, without MST_RREADY_RAND_EN, drive out_rready = 1 whenever out_busy.

Structure
REQ-033 SHALL place FSM state enum, AXI_BURST_INCR, AXI_RESP_OKAY, LFSR seeds and tap mask in shared package axi_tb_pkg.
REQ-034 SHALL implement the tracking FIFO as sub-module axi_ostd_fifo (parameterised width/depth, full/empty flags).

Verification
REQ-035 SHALL test txn_num=3, ready responder, in-order correct R -> 3 AR handshakes, out_done after last rlast, out_err_cnt=0.
REQ-036 SHALL test in_arready held 0 for 10 cycles -> araddr/arlen/arid stable, out_arvalid high throughout.
REQ-037 SHALL test MST_OSTDREQ_NUM=4, txn_num=8, no R -> exactly 4 AR handshakes, then out_arvalid=0.
REQ-038 SHALL test rresp=2'b10 on one beat and rid mismatch on another -> out_err_cnt=2.
REQ-039 SHALL test rlast on beat 1 of arlen=3 burst -> out_err_cnt=1, FIFO pops, next burst checked correctly.
REQ-040 SHALL test srst asserted with 2 bursts outstanding -> IDLE next cycle, all outputs at reset values.
